// File: rtl/execute.sv
// X stage of a five-stage RV32I pipeline: operand forwarding, immediate generation,
// ALU / jump-target computation and branch resolution.
module execute (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_d,
    input  logic [31:0] inst_d,
    input  logic [31:0] rs1_d,
    input  logic [31:0] rs2_d,
    input  logic [31:0] alu_m_bypass,
    input  logic [31:0] wb_w_bypass,
    input  logic [1:0]  alu_in1_bypass,
    input  logic [1:0]  alu_in2_bypass,
    output logic [31:0] PC_x,
    output logic [31:0] inst_x,
    output logic [31:0] alu_x,
    output logic [31:0] rs2_x,
    output logic        PCSel
);

    localparam logic [6:0] OpLcc   = 7'b0000011;
    localparam logic [6:0] OpMcc   = 7'b0010011;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpScc   = 7'b0100011;
    localparam logic [6:0] OpBcc   = 7'b1100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpRcc   = 7'b0110011;

    localparam logic [1:0] BypMx = 2'd1;
    localparam logic [1:0] BypWx = 2'd2;

    localparam logic [31:0] InstNop = 32'h0000_0013;

    logic [31:0] rs1_q, rs2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            PC_x   <= 32'h0;
            inst_x <= InstNop;
            rs1_q  <= 32'h0;
            rs2_q  <= 32'h0;
        end else begin
            PC_x   <= PC_d;
            inst_x <= inst_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
        end
    end

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        alt;

    assign opcode = inst_x[6:0];
    assign funct3 = inst_x[14:12];
    assign funct7 = inst_x[31:25];
    assign shamt  = inst_x[24:20];
    assign alt    = funct7[5];

    // Only funct7[5] selects SUB/SRA; the remaining bits are deliberately ignored.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        imm = 32'h0;
        case (opcode)
            OpLcc, OpMcc, OpJalr: imm = {{20{inst_x[31]}}, inst_x[31:20]};
            OpScc:                imm = {{20{inst_x[31]}}, inst_x[31:25], inst_x[11:7]};
            OpBcc:                imm = {{19{inst_x[31]}}, inst_x[31], inst_x[7],
                                         inst_x[30:25], inst_x[11:8], 1'b0};
            OpLui, OpAuipc:       imm = {inst_x[31:12], 12'h0};
            OpJal:                imm = {{11{inst_x[31]}}, inst_x[31], inst_x[19:12],
                                         inst_x[20], inst_x[30:21], 1'b0};
            default:              imm = 32'h0;
        endcase
    end

    logic [31:0] op_a, op_b;

    always_comb begin
        case (alu_in1_bypass)
            BypMx:   op_a = alu_m_bypass;
            BypWx:   op_a = wb_w_bypass;
            default: op_a = rs1_q;
        endcase
        case (alu_in2_bypass)
            BypMx:   op_b = alu_m_bypass;
            BypWx:   op_b = wb_w_bypass;
            default: op_b = rs2_q;
        endcase
    end

    assign rs2_x = op_b;

    logic taken;

    always_comb begin
        case (funct3)
            3'b000:  taken = (op_a == op_b);
            3'b001:  taken = (op_a != op_b);
            3'b100:  taken = ($signed(op_a) < $signed(op_b));
            3'b101:  taken = ($signed(op_a) >= $signed(op_b));
            3'b110:  taken = (op_a < op_b);
            3'b111:  taken = (op_a >= op_b);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_x = 32'h0;
        PCSel = 1'b0;
        case (opcode)
            OpLui:          alu_x = imm;
            OpAuipc:        alu_x = PC_x + imm;
            OpJal: begin
                alu_x = PC_x + imm;
                PCSel = 1'b1;
            end
            OpJalr: begin
                alu_x = (op_a + imm) & ~32'd1;
                PCSel = 1'b1;
            end
            OpBcc: begin
                alu_x = PC_x + imm;
                PCSel = taken;
            end
            OpLcc, OpScc:   alu_x = op_a + imm;
            OpMcc: begin
                case (funct3)
                    3'b000:  alu_x = op_a + imm;
                    3'b010:  alu_x = {31'h0, $signed(op_a) < $signed(imm)};
                    3'b011:  alu_x = {31'h0, op_a < imm};
                    3'b100:  alu_x = op_a ^ imm;
                    3'b110:  alu_x = op_a | imm;
                    3'b111:  alu_x = op_a & imm;
                    3'b001:  alu_x = op_a << shamt;
                    default: alu_x = alt ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
                endcase
            end
            OpRcc: begin
                case (funct3)
                    3'b000:  alu_x = alt ? op_a - op_b : op_a + op_b;
                    3'b001:  alu_x = op_a << op_b[4:0];
                    3'b010:  alu_x = {31'h0, $signed(op_a) < $signed(op_b)};
                    3'b011:  alu_x = {31'h0, op_a < op_b};
                    3'b100:  alu_x = op_a ^ op_b;
                    3'b110:  alu_x = op_a | op_b;
                    3'b111:  alu_x = op_a & op_b;
                    default: alu_x = alt ? 32'($signed(op_a) >>> op_b[4:0])
                                         : op_a >> op_b[4:0];
                endcase
            end
            default: begin
                alu_x = 32'h0;
                PCSel = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute stage; expected values are hand-computed
// from the RV32I encodings listed beside each vector.
module tb_execute;

    logic        clk;
    logic        reset;
    logic [31:0] PC_d, inst_d, rs1_d, rs2_d;
    logic [31:0] alu_m_bypass, wb_w_bypass;
    logic [1:0]  alu_in1_bypass, alu_in2_bypass;
    logic [31:0] PC_x, inst_x, alu_x, rs2_x;
    logic        PCSel;

    int n_checks = 0;
    int n_errors = 0;

    execute dut (
        .clk            (clk),
        .reset          (reset),
        .PC_d           (PC_d),
        .inst_d         (inst_d),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d),
        .alu_m_bypass   (alu_m_bypass),
        .wb_w_bypass    (wb_w_bypass),
        .alu_in1_bypass (alu_in1_bypass),
        .alu_in2_bypass (alu_in2_bypass),
        .PC_x           (PC_x),
        .inst_x         (inst_x),
        .alu_x          (alu_x),
        .rs2_x          (rs2_x),
        .PCSel          (PCSel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one instruction into decode outputs, clock it into X, then settle.
    task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] a, input logic [31:0] b);
        PC_d           = pc;
        inst_d         = inst;
        rs1_d          = a;
        rs2_d          = b;
        alu_in1_bypass = 2'd0;
        alu_in2_bypass = 2'd0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        PC_d           = 32'h0;
        inst_d         = 32'h0;
        rs1_d          = 32'h0;
        rs2_d          = 32'h0;
        alu_m_bypass   = 32'h0;
        wb_w_bypass    = 32'h0;
        alu_in1_bypass = 2'd0;
        alu_in2_bypass = 2'd0;

        @(posedge clk);
        #1;
        check_eq("rst_inst", inst_x, 32'h0000_0013);
        check_eq("rst_pc", PC_x, 32'h0);
        check_eq("rst_pcsel", {31'h0, PCSel}, 32'h0);
        check_eq("rst_alu", alu_x, 32'h0);
        reset = 1'b0;

        // ADDI x5,x1,-1
        issue(32'h100, 32'hFFF0_8293, 32'd5, 32'd0);
        check_eq("addi_alu", alu_x, 32'd4);
        check_eq("addi_pcsel", {31'h0, PCSel}, 32'h0);

        // ADD x3,x1,x2 with A from MX, B from WX
        issue(32'h104, 32'h0020_81B3, 32'd1, 32'd2);
        alu_m_bypass   = 32'd10;
        wb_w_bypass    = 32'd20;
        alu_in1_bypass = 2'd1;
        alu_in2_bypass = 2'd2;
        #1;
        check_eq("add_byp_alu", alu_x, 32'd30);
        check_eq("add_byp_rs2", rs2_x, 32'd20);
        alu_in2_bypass = 2'd3;
        #1;
        check_eq("add_byp3_rs2", rs2_x, 32'd2);
        check_eq("add_byp3_alu", alu_x, 32'd12);

        // BEQ x1,x2,+8
        issue(32'h0100_0000, 32'h0020_8463, 32'd7, 32'd7);
        check_eq("beq_t_alu", alu_x, 32'h0100_0008);
        check_eq("beq_t_pcsel", {31'h0, PCSel}, 32'h1);
        issue(32'h0100_0000, 32'h0020_8463, 32'd7, 32'd8);
        check_eq("beq_nt_pcsel", {31'h0, PCSel}, 32'h0);

        // BLT taken (-1 < 1), BGE not taken, BLTU not taken (0xFFFFFFFF < 1 false)
        issue(32'h200, 32'h0020_C463, 32'hFFFF_FFFF, 32'd1);
        check_eq("blt_pcsel", {31'h0, PCSel}, 32'h1);
        issue(32'h200, 32'h0020_D463, 32'hFFFF_FFFF, 32'd1);
        check_eq("bge_pcsel", {31'h0, PCSel}, 32'h0);
        issue(32'h200, 32'h0020_E463, 32'hFFFF_FFFF, 32'd1);
        check_eq("bltu_pcsel", {31'h0, PCSel}, 32'h0);

        // JALR x1,3(x2): target bit 0 cleared
        issue(32'h300, 32'h0031_00E7, 32'h0100_0100, 32'd0);
        check_eq("jalr_alu", alu_x, 32'h0100_0102);
        check_eq("jalr_pcsel", {31'h0, PCSel}, 32'h1);

        // JAL x1,-16
        issue(32'h0100_0020, 32'hFF1F_F0EF, 32'd0, 32'd0);
        check_eq("jal_alu", alu_x, 32'h0100_0010);
        check_eq("jal_pcsel", {31'h0, PCSel}, 32'h1);

        // SRA by B[4:0]=4, SLTU / SLT with 1 vs 0xFFFFFFFF
        issue(32'h400, 32'h4020_D1B3, 32'h8000_0000, 32'h24);
        check_eq("sra_alu", alu_x, 32'hF800_0000);
        issue(32'h404, 32'h0020_B1B3, 32'd1, 32'hFFFF_FFFF);
        check_eq("sltu_alu", alu_x, 32'd1);
        issue(32'h408, 32'h0020_A1B3, 32'd1, 32'hFFFF_FFFF);
        check_eq("slt_alu", alu_x, 32'd0);

        // SRAI x1,x1,4 and SLTI x1,x1,-1
        issue(32'h40C, 32'h4040_D093, 32'hF000_0000, 32'd0);
        check_eq("srai_alu", alu_x, 32'hFF00_0000);
        issue(32'h410, 32'hFFF0_A093, 32'd0, 32'd0);
        check_eq("slti_alu", alu_x, 32'd0);

        // LUI x0,0x12345 ; SW x2,-4(x1)
        issue(32'h500, 32'h1234_5037, 32'd0, 32'd0);
        check_eq("lui_alu", alu_x, 32'h1234_5000);
        issue(32'h504, 32'hFE20_AE23, 32'h100, 32'hCAFE_F00D);
        check_eq("sw_alu", alu_x, 32'h0000_00FC);
        check_eq("sw_rs2", rs2_x, 32'hCAFE_F00D);

        // FENCE: no result, no redirect
        issue(32'h508, 32'h0000_000F, 32'd5, 32'd6);
        check_eq("fence_alu", alu_x, 32'h0);
        check_eq("fence_pcsel", {31'h0, PCSel}, 32'h0);

        // Reset dominates a JAL presented on the same edge
        reset = 1'b1;
        issue(32'h0100_0020, 32'hFF1F_F0EF, 32'd9, 32'd9);
        check_eq("midrst_inst", inst_x, 32'h0000_0013);
        check_eq("midrst_pc", PC_x, 32'h0);
        check_eq("midrst_pcsel", {31'h0, PCSel}, 32'h0);
        check_eq("midrst_alu", alu_x, 32'h0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 PC_d  input  32  PC of the instruction leaving decode.
REQ-005 inst_d  input  32  instruction leaving decode.
REQ-006 rs1_d, rs2_d  input  32 each  register-file read data for inst_d.
REQ-007 alu_m_bypass  input  32  ALU result of the instruction in memory stage (MX path).
REQ-008 wb_w_bypass  input  32  writeback data of the instruction in writeback stage (WX path).
REQ-009 alu_in1_bypass, alu_in2_bypass  input  2 each  operand source select: 0=NONE (register), 1=MX, 2=WX, 3 treated as NONE.
REQ-010 PC_x  output  32  registered PC of the X-stage instruction.
REQ-011 inst_x  output  32  registered X-stage instruction.
REQ-012 alu_x  output  32  combinational ALU/target result.
REQ-013 rs2_x  output  32  forwarded rs2 value (store data).
REQ-014 PCSel  output  1  1 = redirect fetch to alu_x.
REQ-015 Internal nets opcode=inst_x[6:0], funct3=inst_x[14:12], funct7=inst_x[31:25], imm (32-bit sign-extended immediate) SHALL exist under these names for hierarchical probing.

Function
REQ-016 Each rising edge without reset: PC_x<=PC_d, inst_x<=inst_d, rs1/rs2 pipeline regs<=rs1_d/rs2_d; no stall or flush inputs.
REQ-017 Operand A = MX ? alu_m_bypass : WX ? wb_w_bypass : registered rs1; operand B and rs2_x likewise from registered rs2; selects applied combinationally in the X cycle.
REQ-018 imm by opcode: I-type (LCC 0000011, MCC 0010011, JALR 1100111) sext inst[31:20]; S (SCC 0100011) sext {inst[31:25],inst[11:7]}; B (BCC 1100011) sext {inst[31],inst[7],inst[30:25],inst[11:8],0}; U (LUI 0110111, AUIPC 0010111) {inst[31:12],12'b0}; J (JAL 1101111) sext {inst[31],inst[19:12],inst[20],inst[30:21],0}; others 0.
REQ-019 alu_x: LUI imm; AUIPC PC_x+imm; JAL PC_x+imm; JALR (A+imm)&~1; BCC PC_x+imm; LCC/SCC A+imm.
REQ-020 MCC by funct3: 000 ADDI, 010 SLTI (signed, 1/0), 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI, 001 SLLI, 101 SRLI if inst[30]=0 else SRAI; shamt=inst[24:20].
REQ-021 RCC (0110011) by funct3: 000 ADD (inst[30]=0)/SUB (inst[30]=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by inst[30], 110 OR, 111 AND; shift amount = B[4:0].
REQ-022 All arithmetic modulo 2^32; overflow ignored.
REQ-023 PCSel=1 for JAL, JALR, and BCC when taken: BEQ 000 A==B, BNE 001 A!=B, BLT 100 signed A<B, BGE 101 signed A>=B, BLTU 110, BGEU 111 unsigned; undefined branch funct3 not taken.
REQ-024 FCC (0001111), CCC (1110011), unknown opcodes: alu_x=0, PCSel=0.
REQ-025 Link value (PC_x+4) is not produced here; alu_x carries the jump target.
REQ-026 Outputs alu_x, rs2_x, PCSel are purely combinational from X-stage registers and bypass inputs; latency inst_d -> alu_x is one cycle.

Reset
REQ-027 On reset at a rising edge: PC_x=0x00000000, inst_x=0x00000013 (ADDI x0,x0,0), rs1/rs2 regs=0; consequently PCSel=0, alu_x=0.
REQ-028 Reset mid-operation discards the X-stage instruction; reset dominates any captured input on that edge.

Verification
REQ-029 Reset asserted one edge -> inst_x=0x00000013, PC_x=0, PCSel=0, alu_x=0.
REQ-030 inst_d=ADDI x5,x1,-1 (0xFFF08293), rs1_d=5, bypass NONE -> next cycle alu_x=4, PCSel=0.
REQ-031 inst_d=ADD x3,x1,x2, rs1_d=1, rs2_d=2, alu_in1_bypass=MX with alu_m_bypass=10, alu_in2_bypass=WX with wb_w_bypass=20 -> alu_x=30, rs2_x=20.
REQ-032 PC_d=0x01000000, inst_d=BEQ x1,x2,+8, rs1_d=rs2_d=7 -> alu_x=0x01000008, PCSel=1; rs2_d=8 -> PCSel=0.
REQ-033 inst_d=JALR x1,3(x2), rs1_d=0x01000100 -> alu_x=0x01000102, PCSel=1; JAL -16 at PC 0x01000020 -> alu_x=0x01000010, PCSel=1.
REQ-034 SRA x3,x1,x2 with A=0x80000000, B=0x24 -> alu_x=0xF8000000; SLTU with A=1, B=0xFFFFFFFF -> alu_x=1; SLT same operands -> 0.
